// File: rtl/mcash_xbar_pkg.sv
// Shared types for the crossbar response return path.
// Bank count, response opcodes and the buffered response record.
package mcash_xbar_pkg;

  localparam int NUM_BANKS = 4;

  typedef enum logic [1:0] {
    RD_DATA = 2'b00,
    WR_ACK  = 2'b01
  } rsp_op_e;

  typedef struct packed {
    logic [2:0]   entry_id;
    rsp_op_e      opcode;
    logic [127:0] data;
  } xbar_rsp_t;

endpackage

// File: rtl/mcash_xbar_rsp_fifo.sv
// Per-bank response buffer, DEPTH entries, no push bypass.
// push_ready is derived from the occupancy register only.
module mcash_xbar_rsp_fifo
  import mcash_xbar_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_valid,
  output logic      push_ready,
  input  xbar_rsp_t push_data,
  input  logic      pop,
  output xbar_rsp_t head,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;
  xbar_rsp_t     mem [DEPTH];

  assign push_ready = (cnt != FULL_CNT);
  assign empty      = (cnt == '0);
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop & ~empty;
  assign head       = mem[rd_ptr];

  // storage write; contents are don't-care until counted in
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mcash_xbar_rsp_return.sv
// Returns bank responses to one channel via round-robin arbitration.
// Optional per-bank handshake counters: MCASH_XBAR_RSP_CNT_EN.
module mcash_xbar_rsp_return
  import mcash_xbar_pkg::*;
#(
  parameter int CH_ID      = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bank0_rsp_valid_i,
  output logic         bank0_rsp_allowIn_o,
  input  logic [2:0]   bank0_rsp_entry_id_i,
  input  logic [1:0]   bank0_rsp_opcode_i,
  input  logic [127:0] bank0_rsp_data_i,
  input  logic         bank1_rsp_valid_i,
  output logic         bank1_rsp_allowIn_o,
  input  logic [2:0]   bank1_rsp_entry_id_i,
  input  logic [1:0]   bank1_rsp_opcode_i,
  input  logic [127:0] bank1_rsp_data_i,
  input  logic         bank2_rsp_valid_i,
  output logic         bank2_rsp_allowIn_o,
  input  logic [2:0]   bank2_rsp_entry_id_i,
  input  logic [1:0]   bank2_rsp_opcode_i,
  input  logic [127:0] bank2_rsp_data_i,
  input  logic         bank3_rsp_valid_i,
  output logic         bank3_rsp_allowIn_o,
  input  logic [2:0]   bank3_rsp_entry_id_i,
  input  logic [1:0]   bank3_rsp_opcode_i,
  input  logic [127:0] bank3_rsp_data_i,
`ifdef MCASH_XBAR_RSP_CNT_EN
  output logic [31:0]  rsp_cnt_bank0_o,
  output logic [31:0]  rsp_cnt_bank1_o,
  output logic [31:0]  rsp_cnt_bank2_o,
  output logic [31:0]  rsp_cnt_bank3_o,
`endif
  output logic         mcash_ch_rsp_valid_o,
  input  logic         mcash_ch_rsp_allowIn_i,
  output logic [1:0]   mcash_ch_rsp_bank_id_o,
  output logic [2:0]   mcash_ch_rsp_entry_id_o,
  output logic [1:0]   mcash_ch_rsp_opcode_o,
  output logic [127:0] mcash_ch_rsp_data_o
);

  if (CH_ID < 0) begin : g_bad_ch
    $error("CH_ID must be non-negative");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic [NUM_BANKS-1:0] bank_vld;
  logic [NUM_BANKS-1:0] bank_rdy;
  logic [NUM_BANKS-1:0] empty;
  logic [NUM_BANKS-1:0] pop;
  xbar_rsp_t            bank_rsp [NUM_BANKS];
  xbar_rsp_t            head     [NUM_BANKS];

  logic [1:0] rr_q;
  logic       lock_q;
  logic [1:0] lock_bank_q;
  logic [1:0] gnt;
  logic [1:0] idx;
  logic       found;
  logic       ch_valid;
  logic       hs;

  assign bank_vld = {bank3_rsp_valid_i, bank2_rsp_valid_i,
                     bank1_rsp_valid_i, bank0_rsp_valid_i};

  assign bank_rsp[0] = '{entry_id: bank0_rsp_entry_id_i,
                         opcode:   rsp_op_e'(bank0_rsp_opcode_i),
                         data:     bank0_rsp_data_i};
  assign bank_rsp[1] = '{entry_id: bank1_rsp_entry_id_i,
                         opcode:   rsp_op_e'(bank1_rsp_opcode_i),
                         data:     bank1_rsp_data_i};
  assign bank_rsp[2] = '{entry_id: bank2_rsp_entry_id_i,
                         opcode:   rsp_op_e'(bank2_rsp_opcode_i),
                         data:     bank2_rsp_data_i};
  assign bank_rsp[3] = '{entry_id: bank3_rsp_entry_id_i,
                         opcode:   rsp_op_e'(bank3_rsp_opcode_i),
                         data:     bank3_rsp_data_i};

  assign bank0_rsp_allowIn_o = bank_rdy[0];
  assign bank1_rsp_allowIn_o = bank_rdy[1];
  assign bank2_rsp_allowIn_o = bank_rdy[2];
  assign bank3_rsp_allowIn_o = bank_rdy[3];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_fifo
    mcash_xbar_rsp_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (bank_vld[i]),
      .push_ready (bank_rdy[i]),
      .push_data  (bank_rsp[i]),
      .pop        (pop[i]),
      .head       (head[i]),
      .empty      (empty[i])
    );
  end

  assign ch_valid = ~&empty;
  assign hs       = ch_valid & mcash_ch_rsp_allowIn_i;

  // grant: held bank while stalled, else first non-empty from rr_q
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    if (lock_q) begin
      gnt   = lock_bank_q;
      found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        idx = rr_q + 2'(k);
        if (!found && !empty[idx]) begin
          gnt   = idx;
          found = 1'b1;
        end
      end
    end
  end

  // only the granted bank is popped, and only on a handshake
  always_comb begin
    pop      = '0;
    pop[gnt] = hs;
  end

  // channel payload straight from the granted head; zero when idle
  always_comb begin
    mcash_ch_rsp_valid_o    = ch_valid;
    mcash_ch_rsp_bank_id_o  = '0;
    mcash_ch_rsp_entry_id_o = '0;
    mcash_ch_rsp_opcode_o   = '0;
    mcash_ch_rsp_data_o     = '0;
    if (ch_valid) begin
      mcash_ch_rsp_bank_id_o  = gnt;
      mcash_ch_rsp_entry_id_o = head[gnt].entry_id;
      mcash_ch_rsp_opcode_o   = head[gnt].opcode;
      if (head[gnt].opcode != WR_ACK)
        mcash_ch_rsp_data_o = head[gnt].data;
    end
  end

  // rr pointer advances past the winner; stall freezes the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_bank_q <= '0;
    end else if (hs) begin
      rr_q   <= gnt + 2'd1;
      lock_q <= 1'b0;
    end else if (ch_valid) begin
      lock_q      <= 1'b1;
      lock_bank_q <= gnt;
    end
  end

`ifdef MCASH_XBAR_RSP_CNT_EN
  logic [31:0] cnt_q [NUM_BANKS];

  // handshakes per source bank, free-running with wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) cnt_q[b] <= '0;
    end else if (hs) begin
      cnt_q[gnt] <= cnt_q[gnt] + 32'd1;
    end
  end

  assign rsp_cnt_bank0_o = cnt_q[0];
  assign rsp_cnt_bank1_o = cnt_q[1];
  assign rsp_cnt_bank2_o = cnt_q[2];
  assign rsp_cnt_bank3_o = cnt_q[3];
`endif

endmodule
